// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: stall, jump, relative branch,
// and call/return through a small internal return-address stack.
module pc_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int RESET_ADDR  = 0,
  parameter int STACK_DEPTH = 4,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump,
  input  logic              branch,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] counter,
  output logic [DEPTH_W-1:0] depth,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  logic [ADDR_W-1:0]  counter_q, counter_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0]  stack_d [STACK_DEPTH];

  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  stack_top;
  logic               full, empty;

  assign pc_inc = counter_q + ADDR_W'(1);
  assign full   = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty  = (depth_q == '0);

  // Entry depth-1 is the top; compare-select keeps indices in range for any depth.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (DEPTH_W'(i + 1) == depth_q) stack_top = stack_q[i];
    end
  end

  always_comb begin
    counter_d = counter_q;
    depth_d   = depth_q;
    err_d     = err_q;
    stack_d   = stack_q;
    if (stall) begin
      counter_d = counter_q;
    end else if (ret) begin
      if (!empty) begin
        counter_d = stack_top;
        depth_d   = depth_q - DEPTH_W'(1);
      end else begin
        counter_d = pc_inc;
        err_d     = 1'b1;
      end
    end else if (call) begin
      if (!full) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (DEPTH_W'(i) == depth_q) stack_d[i] = pc_inc;
        end
        counter_d = target;
        depth_d   = depth_q + DEPTH_W'(1);
      end else begin
        counter_d = pc_inc;
        err_d     = 1'b1;
      end
    end else if (jump) begin
      counter_d = target;
    end else if (branch) begin
      counter_d = counter_q + offset;
    end else begin
      counter_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= ADDR_W'(RESET_ADDR);
      depth_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      depth_q   <= depth_d;
      err_q     <= err_d;
    end
  end

  // Stack contents are meaningless once depth is cleared, so they need no reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign counter     = counter_q;
  assign depth       = depth_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (ADDR_W=6, STACK_DEPTH=4): table of
// vectors with hand-derived expectations, checked through a scoreboard queue.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset, stall, jump, branch, call, ret;
  logic [5:0] target, offset;
  logic [5:0] counter;
  logic [2:0] depth;
  logic       stack_full, stack_empty, stack_err;

  pc_sequencer #(.ADDR_W(6), .RESET_ADDR(0), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .branch(branch),
    .call(call), .ret(ret), .target(target), .offset(offset),
    .counter(counter), .depth(depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, stl, jmp, brn, cal, rt;
    logic [5:0] tgt, off;
    logic [5:0] cnt;
    logic [2:0] dep;
    logic       err;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] cnt;
    logic [2:0] dep;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(string nm, int r, int s, int j, int b, int c, int t,
                              int tg, int of, int ec, int ed, int ee);
    vec_t v;
    v.name = nm; v.rst = r[0]; v.stl = s[0]; v.jmp = j[0]; v.brn = b[0];
    v.cal = c[0]; v.rt = t[0]; v.tgt = tg[5:0]; v.off = of[5:0];
    v.cnt = ec[5:0]; v.dep = ed[2:0]; v.err = ee[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the expectation, then compare after the edge.
  task automatic step(input vec_t v);
    exp_t e, got;
    @(negedge clk);
    reset = v.rst; stall = v.stl; jump = v.jmp; branch = v.brn;
    call = v.cal; ret = v.rt; target = v.tgt; offset = v.off;
    e.name = v.name; e.cnt = v.cnt; e.dep = v.dep; e.err = v.err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      got = sb.pop_front();
      chk({got.name, ".counter"}, counter, got.cnt);
      chk({got.name, ".depth"}, depth, got.dep);
      chk({got.name, ".stack_err"}, stack_err, got.err);
      chk({got.name, ".stack_full"}, stack_full, got.dep == 3'd4);
      chk({got.name, ".stack_empty"}, stack_empty, got.dep == 3'd0);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 0; jump = 0; branch = 0; call = 0; ret = 0;
    target = '0; offset = '0;

    step(mk("reset", 1,0,0,0,0,0, 0,0, 0,0,0));

    // Free run: 1..63, wrap to 0, then 1.
    for (int i = 1; i <= 65; i++) begin
      step(mk($sformatf("wrap%0d", i), 0,0,0,0,0,0, 0,0, i % 64, 0, 0));
    end

    //          name          r s j b c t  tgt off  cnt dep err
    vecs.push_back(mk("jmp10",     0,0,1,0,0,0, 10, 0, 10, 0, 0));
    vecs.push_back(mk("brn_m2",    0,0,0,1,0,0,  0,62,  8, 0, 0));
    vecs.push_back(mk("jmp40",     0,0,1,0,0,0, 40, 0, 40, 0, 0));
    vecs.push_back(mk("brn_wrap",  0,0,0,1,0,0,  0,30,  6, 0, 0));
    vecs.push_back(mk("jmp5",      0,0,1,0,0,0,  5, 0,  5, 0, 0));
    vecs.push_back(mk("call20",    0,0,0,0,1,0, 20, 0, 20, 1, 0));
    vecs.push_back(mk("idle21",    0,0,0,0,0,0,  0, 0, 21, 1, 0));
    vecs.push_back(mk("idle22",    0,0,0,0,0,0,  0, 0, 22, 1, 0));
    vecs.push_back(mk("ret6",      0,0,0,0,0,1,  0, 0,  6, 0, 0));
    vecs.push_back(mk("ovf_c1",    0,0,0,0,1,0, 30, 0, 30, 1, 0));
    vecs.push_back(mk("ovf_c2",    0,0,0,0,1,0, 30, 0, 30, 2, 0));
    vecs.push_back(mk("ovf_c3",    0,0,0,0,1,0, 30, 0, 30, 3, 0));
    vecs.push_back(mk("ovf_c4",    0,0,0,0,1,0, 30, 0, 30, 4, 0));
    vecs.push_back(mk("ovf_c5",    0,0,0,0,1,0, 30, 0, 31, 4, 1));
    vecs.push_back(mk("unf_r1",    0,0,0,0,0,1,  0, 0, 31, 3, 1));
    vecs.push_back(mk("unf_r2",    0,0,0,0,0,1,  0, 0, 31, 2, 1));
    vecs.push_back(mk("unf_r3",    0,0,0,0,0,1,  0, 0, 31, 1, 1));
    vecs.push_back(mk("unf_r4",    0,0,0,0,0,1,  0, 0,  7, 0, 1));
    vecs.push_back(mk("unf_r5",    0,0,0,0,0,1,  0, 0,  8, 0, 1));
    vecs.push_back(mk("stall1",    0,1,1,0,1,1, 50, 0,  8, 0, 1));
    vecs.push_back(mk("stall2",    0,1,1,0,1,1, 50, 0,  8, 0, 1));
    vecs.push_back(mk("stall3",    0,1,1,0,1,1, 50, 0,  8, 0, 1));
    vecs.push_back(mk("prio_call", 0,0,1,1,1,0, 12, 5, 12, 1, 1));
    vecs.push_back(mk("prio_ret",  0,0,1,0,1,1,  3, 0,  9, 0, 1));
    vecs.push_back(mk("fill1",     0,0,0,0,1,0, 20, 0, 20, 1, 1));
    vecs.push_back(mk("fill2",     0,0,0,0,1,0, 20, 0, 20, 2, 1));
    vecs.push_back(mk("fill3",     0,0,0,0,1,0, 20, 0, 20, 3, 1));
    vecs.push_back(mk("rst_ret",   1,0,0,0,0,1,  0, 0,  0, 0, 0));
    vecs.push_back(mk("post_rst",  0,0,0,0,0,0,  0, 0,  1, 0, 0));
    vecs.push_back(mk("jmp63",     0,0,1,0,0,0, 63, 0, 63, 0, 0));
    vecs.push_back(mk("call_wrap", 0,0,0,0,1,0,  2, 0,  2, 1, 0));
    vecs.push_back(mk("ret_wrap",  0,0,0,0,0,1,  0, 0,  0, 0, 0));
    vecs.push_back(mk("unf_fresh", 0,0,0,0,0,1,  0, 0,  1, 0, 1));
    vecs.push_back(mk("rst_clr",   1,0,0,0,0,0,  0, 0,  0, 0, 0));

    foreach (vecs[i]) step(vecs[i]);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the free-running program counter.
- Generates the instruction address for the fetch stage.
- Supports stall, absolute jump, PC-relative branch, and call/return through an internal return-address stack.
- Sits between the control unit (which produces the control strobes) and instruction memory (which consumes `counter`).

Parameters:
- ADDR_W, 6, width of the program address in bits. Legal range 2..32.
- RESET_ADDR, 0, value loaded into the PC on reset. Must fit in ADDR_W bits.
- STACK_DEPTH, 4, number of return-address entries. Legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and stack this cycle.
- jump  input  1  load `target` into PC.
- branch  input  1  add signed `offset` to PC.
- call  input  1  push PC+1, then load `target`.
- ret  input  1  pop the top of stack into PC.
- target  input  ADDR_W  absolute destination for jump and call.
- offset  input  ADDR_W  two's-complement displacement for branch.
- counter  output  ADDR_W  current program address (registered).
- depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  high when depth == STACK_DEPTH.
- stack_empty  output  1  high when depth == 0.
- stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Interface: single clock domain, clk. reset is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values: counter = RESET_ADDR, depth = 0, stack_full = 0 (1 only if STACK_DEPTH == 0, which is illegal), stack_empty = 1, stack_err = 0. Stack entry contents are don't-care.
- Reset mid-operation: reset overrides every control input in that cycle and discards all stack contents.
- Outputs are registered. A control input sampled at edge N is reflected on `counter` after edge N; latency is 1 cycle.
- Update priority per cycle (first match wins): reset > stall > ret > call > jump > branch > increment.
  - stall: counter, stack and depth are unchanged. stack_err is unchanged.
  - ret, depth > 0: counter <= stack[depth-1]; depth <= depth-1.
  - ret, depth == 0 (underflow): counter <= counter+1; stack_err <= 1; depth stays 0.
  - call, depth < STACK_DEPTH: stack[depth] <= counter+1 (mod 2^ADDR_W); counter <= target; depth <= depth+1.
  - call, depth == STACK_DEPTH (overflow): no push; counter <= counter+1; stack_err <= 1.
  - jump: counter <= target.
  - branch: counter <= counter + offset. Offset is sign-interpreted; the result is truncated to ADDR_W bits.
  - none asserted: counter <= counter+1.
- Lower-priority strobes asserted in the same cycle as a higher-priority one are ignored, with no side effects. Example: call+jump performs the call only.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W and wraps silently. Wrap is not an error. counter = 2^ADDR_W-1 increments to 0.
- stack_err is sticky. It is cleared only by reset.
- stack_full and stack_empty are combinational decodes of the registered depth. They are therefore valid in the same cycle as depth.
- Stack storage is a LIFO register array indexed by depth. No read-before-write hazard exists, because push and pop are mutually exclusive within a cycle.

Test Plan:
- Reset and wrap (ADDR_W=6): assert reset 1 cycle, then release with no strobes for 65 cycles -> counter = 0 after reset, counts 1..63, wraps to 0, then reads 1; stack_empty = 1 throughout.
- Branch and jump: at counter = 10, branch with offset = 6'b111110 (-2) -> counter = 8. Next cycle, jump with target = 40 -> 40. Then branch with offset = 30 from 40 -> 6 (70 mod 64).
- Call and return: at counter = 5, call with target = 20 -> counter = 20, depth = 1. Two idle cycles -> 22. ret -> counter = 6, depth = 0, stack_err = 0.
- Overflow and underflow (STACK_DEPTH=4): five consecutive calls to target = 30 -> first four push and set depth = 4, stack_full = 1; the fifth gives counter = 31 and stack_err = 1. Then five rets -> four pops, then counter increments with stack_err still 1.
- Stall and priority: stall asserted together with call, jump and ret for 3 cycles -> counter and depth frozen. Release, then assert call+jump+branch with target = 12 -> call only: counter = 12, depth +1.
- Reset mid-operation: with depth = 3 and stack_err = 1, assert reset coincident with ret -> counter = RESET_ADDR, depth = 0, stack_err = 0, and the ret has no effect.
